// File: rtl/fpmath_pkg.sv
// Shared definitions for the fpmath datapath: operand classes, flag bit positions,
// default format constants and the canonical quiet-NaN builder.
package fpmath_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int W         = 1 + EXP_W_DEF + MAN_W_DEF;
    localparam int BIAS      = 2**(EXP_W_DEF-1) - 1;
    localparam int EXP_MAX   = 2**EXP_W_DEF - 1;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // Word is built in 64 bits; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
        r[man_w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign/exponent/significand and classifies it.
// Subnormals flush to zero; NaN/inf/zero report an all-zero significand.
module fp_unpack
    import fpmath_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] x,
    output logic                 sgn,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig,
    output logic [1:0]           cls,
    output logic                 snan
);
    logic [MAN_W-1:0] frac;

    always_comb begin
        sgn   = x[EXP_W+MAN_W];
        exp_o = x[EXP_W+MAN_W-1:MAN_W];
        frac  = x[MAN_W-1:0];
        cls   = NORM;
        sig   = {1'b1, frac};
        snan  = 1'b0;
        if (exp_o == '0) begin
            cls = ZERO;
            sig = '0;
        end else if (&exp_o) begin
            sig = '0;
            if (frac == '0) begin
                cls = INF;
            end else begin
                cls  = NAN;
                snan = ~frac[MAN_W-1];
            end
        end
    end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined FP multiplier (unpack/exponent, significand product,
// normalise/round/pack) with a single global stall driven by output back-pressure.
module fpmul_pipe
    import fpmath_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic [3:0]           flags,
    output logic                 over_mul_under
);
    localparam int WD = 1 + EXP_W + MAN_W;
    localparam int PW = 2*MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(2**(EXP_W-1) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] EONE_S = EW'(1);
    localparam logic signed [EW-1:0] EZERO_S = EW'(0);
    localparam logic [63:0] QNAN64 = qnan_bits(EXP_W, MAN_W);
    localparam logic [WD-1:0] QNAN = QNAN64[WD-1:0];

    // Special-case result is resolved in S1 and rides along, overriding S3 arithmetic.
    typedef struct packed {
        logic                 sign;
        logic signed [EW-1:0] esum;
        logic                 spec;
        logic [WD-1:0]        spc_c;
        logic [3:0]           spc_f;
    } hdr_t;

    typedef struct packed {
        hdr_t           h;
        logic [MAN_W:0] siga;
        logic [MAN_W:0] sigb;
    } s1_t;

    typedef struct packed {
        hdr_t          h;
        logic [PW-1:0] prod;
    } s2_t;

    logic             sgn_a, sgn_b, snan_a, snan_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   sig_a, sig_b;
    logic [1:0]       cls_a, cls_b;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .x(a), .sgn(sgn_a), .exp_o(exp_a), .sig(sig_a), .cls(cls_a), .snan(snan_a)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .x(b), .sgn(sgn_b), .exp_o(exp_b), .sig(sig_b), .cls(cls_b), .snan(snan_b)
    );

    logic             stall, adv;
    logic [2:0]       vld_pipe_q, vld_pipe_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [WD-1:0]    c_q, c_d;
    logic [3:0]       flags_q, flags_d;
    logic             nan_any, inf_any, zero_any, inf_zero, s1_sign;

    assign stall          = vld_pipe_q[2] & ~out_ready;
    assign adv            = ~stall;
    assign in_ready       = adv;
    assign out_valid      = vld_pipe_q[2];
    assign c              = c_q;
    assign flags          = flags_q;
    assign over_mul_under = flags_q[FLG_OVF] | flags_q[FLG_UNF];

    always_comb begin
        nan_any  = (cls_a == NAN) | (cls_b == NAN);
        inf_any  = (cls_a == INF) | (cls_b == INF);
        zero_any = (cls_a == ZERO) | (cls_b == ZERO);
        inf_zero = inf_any & zero_any;
        s1_sign  = sgn_a ^ sgn_b;
        s1_d     = s1_q;
        if (adv) begin
            s1_d.h.sign  = s1_sign;
            s1_d.h.esum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
            s1_d.h.spec  = nan_any | inf_any | zero_any;
            s1_d.h.spc_f = '0;
            s1_d.h.spc_f[FLG_INV] = inf_zero | snan_a | snan_b;
            if (nan_any | inf_zero)
                s1_d.h.spc_c = QNAN;
            else if (inf_any)
                s1_d.h.spc_c = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                s1_d.h.spc_c = {s1_sign, {(WD-1){1'b0}}};
            s1_d.siga = sig_a;
            s1_d.sigb = sig_b;
        end
    end

    always_comb begin
        s2_d = s2_q;
        if (adv) begin
            s2_d.h    = s1_q.h;
            s2_d.prod = PW'(s1_q.siga) * PW'(s1_q.sigb);
        end
    end

    logic [PW-1:0]        norm;
    logic signed [EW-1:0] e_n, e_r;
    logic [MAN_W:0]       mant, mant_r;
    logic                 guard, sticky, inc;
    logic [WD-1:0]        res_c;
    logic [3:0]           res_f;

    always_comb begin
        norm   = s2_q.prod[PW-1] ? s2_q.prod : (s2_q.prod << 1);
        e_n    = s2_q.h.esum + (s2_q.prod[PW-1] ? EONE_S : EZERO_S);
        mant   = norm[PW-1 -: MAN_W+1];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
        inc    = (ROUND != 0) && guard && (sticky || mant[0]);
        // A rounding carry wraps the hidden bit to 0 and leaves the fraction all-zero.
        mant_r = mant + {{MAN_W{1'b0}}, inc};
        e_r    = mant_r[MAN_W] ? e_n : e_n + EONE_S;
        res_f  = '0;
        res_f[FLG_INX] = guard | sticky;
        if (e_r >= EMAX_S) begin
            res_c = {s2_q.h.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f[FLG_OVF] = 1'b1;
            res_f[FLG_INX] = 1'b1;
        end else if (e_r <= EZERO_S) begin
            res_c = {s2_q.h.sign, {(WD-1){1'b0}}};
            res_f[FLG_UNF] = 1'b1;
            res_f[FLG_INX] = |s2_q.prod;
        end else begin
            res_c = {s2_q.h.sign, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
        if (s2_q.h.spec) begin
            res_c = s2_q.h.spc_c;
            res_f = s2_q.h.spc_f;
        end

        vld_pipe_d = adv ? {vld_pipe_q[1:0], in_valid} : vld_pipe_q;
        c_d        = c_q;
        flags_d    = flags_q;
        if (adv && vld_pipe_q[1]) begin
            c_d     = res_c;
            flags_d = res_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            c_q        <= '0;
            flags_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            c_q        <= c_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Directed-vector bench for fpmul_pipe (binary32): RNE and truncating instances
// side by side, plus back-pressure and mid-flight reset sequences.
module tb_fpmul_pipe;

    logic        clk, rst, in_valid, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, over_mul_under;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        rz_in_ready, rz_out_valid, rz_omu;
    logic [31:0] rz_c;
    logic [3:0]  rz_flags;

    fpmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flags(flags), .over_mul_under(over_mul_under)
    );

    fpmul_pipe #(.EXP_W(8), .MAN_W(23), .ROUND(0)) u_rz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rz_in_ready),
        .a(a), .b(b), .out_valid(rz_out_valid), .out_ready(out_ready),
        .c(rz_c), .flags(rz_flags), .over_mul_under(rz_omu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, c, c_rz;
        logic [3:0]  f;
    } vec_t;

    vec_t tv [14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered at posedge+1 with an empty pipeline; leaves one cycle after the result is taken.
    task automatic run_vec(input int i, input logic chk_lat);
        int lat;
        a = tv[i].a; b = tv[i].b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (chk_lat) check($sformatf("v%0d latency", i), lat, 3);
        check($sformatf("v%0d out_valid", i), out_valid, 1);
        check($sformatf("v%0d c", i), c, tv[i].c);
        check($sformatf("v%0d flags", i), flags, tv[i].f);
        check($sformatf("v%0d over_mul_under", i), over_mul_under, tv[i].f[2] | tv[i].f[1]);
        check($sformatf("v%0d c_trunc", i), rz_c, tv[i].c_rz);
        @(posedge clk); #1;
    endtask

    int          idx, got;
    logic [31:0] held;
    logic        held_vld, acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'h0};
        tv[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 32'h3F800002, 4'h1};
        tv[2]  = '{32'h3F800003, 32'h3F800003, 32'h3F800006, 32'h3F800006, 4'h1};
        tv[3]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 32'h40100001, 4'h1};
        tv[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 32'h7F800000, 4'h5};
        tv[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 32'h00000000, 4'h3};
        tv[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'h8};
        tv[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'h0};
        tv[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'h0};
        tv[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'h8};
        tv[10] = '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 4'h0};
        tv[11] = '{32'h00000001, 32'h40000000, 32'h00000000, 32'h00000000, 4'h0};
        tv[12] = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 32'hC0C00000, 4'h0};
        tv[13] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 4'h0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset out_valid", out_valid, 0);
        check("reset c", c, 0);
        check("reset flags", flags, 0);
        check("reset over_mul_under", over_mul_under, 0);
        check("reset in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(i, i == 0);

        // Back-to-back stream with two cycles of output back-pressure.
        idx = 0; got = 0; held = '0; held_vld = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc == 4 || cyc == 5);
            if (idx < 6) begin
                in_valid = 1'b1; a = tv[idx].a; b = tv[idx].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("bp in_ready cyc%0d", cyc), in_ready, !(out_valid && !out_ready));
            if (out_valid && !out_ready) begin
                if (held_vld) check("bp c hold", c, held);
                held = c; held_vld = 1'b1;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp r%0d c", got), c, tv[got].c);
                check($sformatf("bp r%0d flags", got), flags, tv[got].f);
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp results", got, 6);
        check("bp stall seen", held_vld, 1);
        @(posedge clk); #1;

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            a = tv[4+i].a; b = tv[4+i].b; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid out_valid", out_valid, 0);
        check("mid flags", flags, 0);
        check("mid in_ready", in_ready, 1);
        check("mid c", c, 0);
        run_vec(1, 1'b1);
        check("mid no stale result", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
